// File: rtl/cnn_ctrl_pkg.sv
// Shared types and constants for the CNN layer sequencer: FSM state encoding,
// per-mode channel tables and the channel-count lookup.
package cnn_ctrl_pkg;

    localparam int NUM_LAYERS = 4;
    localparam int CH_W       = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    // Entry [0] is layer 0 (the rightmost element of each concatenation).
    localparam logic [3:0][CH_W-1:0] CH_TBL_M0 = {6'd10, 6'd16, 6'd8,  6'd4};
    localparam logic [3:0][CH_W-1:0] CH_TBL_M1 = {6'd10, 6'd32, 6'd16, 6'd8};

    function automatic logic [CH_W-1:0] ch_lookup(input logic m, input logic [1:0] idx);
        return m ? CH_TBL_M1[idx] : CH_TBL_M0[idx];
    endfunction

endpackage

// File: rtl/result_burst_reader.sv
// Turns a single start request into BATCH consecutive result-buffer reads with
// a wrapping address; abort stops a burst, clear rewinds the address.
module result_burst_reader #(
    parameter int BATCH       = 3,
    parameter int NUM_RESULTS = 42,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              clear,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              batch_done
);

    localparam int                CNT_W    = $clog2(BATCH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BATCH - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(NUM_RESULTS - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_addr;
    logic              r_batch_done;
    logic [ADDR_W-1:0] w_addr_nxt;

    assign w_addr_nxt = (r_addr == ADDR_MAX) ? '0 : r_addr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_rd_en      <= 1'b0;
            r_addr       <= '0;
            r_batch_done <= 1'b0;
        end else begin
            if (abort) begin
                r_cnt        <= '0;
                r_rd_en      <= 1'b0;
                r_batch_done <= 1'b0;
            end else if (r_rd_en) begin
                // The address advances on every read, including the last one.
                r_addr <= w_addr_nxt;
                if (r_cnt == CNT_LAST) begin
                    r_cnt        <= '0;
                    r_rd_en      <= 1'b0;
                    r_batch_done <= 1'b0;
                end else begin
                    r_cnt        <= r_cnt + 1'b1;
                    r_batch_done <= (r_cnt == CNT_LAST - 1'b1);
                end
            end else if (start) begin
                r_cnt        <= '0;
                r_rd_en      <= 1'b1;
                r_batch_done <= (BATCH == 1);
            end
            // NOTE: a later non-blocking write in the same block wins, so clear overrides the increment.
            if (clear) r_addr <= '0;
        end
    end

    assign rd_en      = r_rd_en;
    assign rd_addr    = r_addr;
    assign batch_done = r_batch_done;

endmodule

// File: rtl/cnn_layer_seq.sv
// Layer sequencer: launches NUM_LAYERS layers one at a time, drives their channel
// configuration, detects stalled layers, and schedules burst readout when done.
module cnn_layer_seq
    import cnn_ctrl_pkg::*;
#(
    parameter int NUM_LAYERS  = cnn_ctrl_pkg::NUM_LAYERS,
    parameter int BATCH       = 3,
    parameter int NUM_RESULTS = 42,
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              cal_start,
    input  logic              mode,
    input  logic              layer_done,
    input  logic              rd_en,
    output logic              layer_start,
    output logic [1:0]        layer_idx,
    output logic [CH_W-1:0]   ch_cfg,
    output logic              mode_lat,
    output logic              busy,
    output logic              cal_done,
    output logic              timeout_err,
    output logic              res_rd_en,
    output logic [ADDR_W-1:0] res_rd_addr,
    output logic              batch_done
);

    localparam logic [1:0]  LAST_LAYER = 2'(NUM_LAYERS - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYC - 1);

    state_t          r_state;
    logic [15:0]     r_to_cnt;
    logic            r_layer_start;
    logic [1:0]      r_layer_idx;
    logic [CH_W-1:0] r_ch_cfg;
    logic            r_mode_lat;
    logic            r_busy;
    logic            r_cal_done;
    logic            r_timeout_err;

    logic w_accept;
    logic w_burst_start;

    assign w_accept      = cal_start && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
    assign w_burst_start = (r_state == ST_DONE) && rd_en && !cal_start;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_to_cnt      <= '0;
            r_layer_start <= 1'b0;
            r_layer_idx   <= '0;
            r_ch_cfg      <= '0;
            r_mode_lat    <= 1'b1;
            r_busy        <= 1'b0;
            r_cal_done    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_layer_start <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (cal_start) begin
                        r_mode_lat    <= mode;
                        r_layer_idx   <= '0;
                        // NOTE: ch_cfg is built from the incoming mode, not r_mode_lat, so it is valid with layer_start.
                        r_ch_cfg      <= ch_lookup(mode, 2'd0);
                        r_cal_done    <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_busy        <= 1'b1;
                        r_layer_start <= 1'b1;
                        r_state       <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_to_cnt <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion in the timeout cycle still counts as success.
                    if (layer_done) begin
                        if (r_layer_idx == LAST_LAYER) begin
                            r_busy     <= 1'b0;
                            r_cal_done <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_layer_idx   <= r_layer_idx + 1'b1;
                            r_ch_cfg      <= ch_lookup(r_mode_lat, r_layer_idx + 1'b1);
                            r_layer_start <= 1'b1;
                            r_state       <= ST_LAUNCH;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_busy        <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_ERR;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    result_burst_reader #(
        .BATCH       (BATCH),
        .NUM_RESULTS (NUM_RESULTS),
        .ADDR_W      (ADDR_W)
    ) u_reader (
        .clk        (sys_clk),
        .rst        (rst),
        .start      (w_burst_start),
        .abort      (w_accept),
        .clear      (w_accept),
        .rd_en      (res_rd_en),
        .rd_addr    (res_rd_addr),
        .batch_done (batch_done)
    );

    assign layer_start = r_layer_start;
    assign layer_idx   = r_layer_idx;
    assign ch_cfg      = r_ch_cfg;
    assign mode_lat    = r_mode_lat;
    assign busy        = r_busy;
    assign cal_done    = r_cal_done;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Directed testbench for cnn_layer_seq with hand-computed expectations.
`timescale 1ns/1ps
module tb_cnn_layer_seq;

    logic       sys_clk = 1'b0;
    logic       rst, cal_start, mode, layer_done, rd_en;
    logic       layer_start, busy, cal_done, timeout_err, mode_lat, res_rd_en, batch_done;
    logic [1:0] layer_idx;
    logic [5:0] ch_cfg, res_rd_addr;

    int n_pass  = 0;
    int n_total = 0;
    int start_cnt = 0;

    localparam logic [20:0] RESET_VEC = {1'b0, 2'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0};

    cnn_layer_seq #(
        .NUM_LAYERS  (4),
        .BATCH       (3),
        .NUM_RESULTS (42),
        .ADDR_W      (6),
        .TIMEOUT_CYC (20)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .cal_start   (cal_start),
        .mode        (mode),
        .layer_done  (layer_done),
        .rd_en       (rd_en),
        .layer_start (layer_start),
        .layer_idx   (layer_idx),
        .ch_cfg      (ch_cfg),
        .mode_lat    (mode_lat),
        .busy        (busy),
        .cal_done    (cal_done),
        .timeout_err (timeout_err),
        .res_rd_en   (res_rd_en),
        .res_rd_addr (res_rd_addr),
        .batch_done  (batch_done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) if (layer_start === 1'b1) start_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [20:0] outs();
        return {layer_start, layer_idx, ch_cfg, mode_lat, busy, cal_done,
                timeout_err, res_rd_en, res_rd_addr, batch_done};
    endfunction

    task automatic test_reset();
        rst = 1'b1; cal_start = 1'b0; mode = 1'b0; layer_done = 1'b0; rd_en = 1'b0;
        tick(); tick();
        n_total++;
        if (outs() !== RESET_VEC) $display("FAIL reset_values: got %h want %h", outs(), RESET_VEC);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    // One full calculation; optionally pulses cal_start during WAIT of layer 1.
    task automatic test_run(input logic m, input logic [3:0][5:0] exp_ch, input logic inject);
        int s0;
        s0 = start_cnt;
        cal_start = 1'b1; mode = m;
        tick();
        cal_start = 1'b0; mode = 1'b0;
        for (int l = 0; l < 4; l++) begin
            n_total++;
            if ({layer_start, busy, layer_idx, ch_cfg, mode_lat} !== {1'b1, 1'b1, 2'(l), exp_ch[l], m})
                $display("FAIL launch_l%0d: got ls=%b busy=%b idx=%0d ch=%0d ml=%b want 1 1 %0d %0d %b",
                         l, layer_start, busy, layer_idx, ch_cfg, mode_lat, l, exp_ch[l], m);
            else n_pass++;
            for (int j = 0; j < 5; j++) begin
                if (inject && l == 1 && j == 2) begin cal_start = 1'b1; mode = ~m; end
                tick();
                cal_start = 1'b0; mode = 1'b0;
            end
            layer_done = 1'b1;
            tick();
            layer_done = 1'b0;
        end
        n_total++;
        if ({cal_done, busy, layer_start} !== 3'b100)
            $display("FAIL cal_done: got done=%b busy=%b ls=%b want 1 0 0", cal_done, busy, layer_start);
        else n_pass++;
        n_total++;
        if (start_cnt - s0 !== 4) $display("FAIL start_pulses: got %0d want 4", start_cnt - s0);
        else n_pass++;
    endtask

    task automatic test_readout();
        for (int b = 0; b < 15; b++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            for (int k = 0; k < 3; k++) begin
                n_total++;
                if ({res_rd_en, res_rd_addr, batch_done} !== {1'b1, 6'((3 * b + k) % 42), (k == 2)})
                    $display("FAIL burst%0d_read%0d: got en=%b addr=%0d bd=%b want 1 %0d %b",
                             b, k, res_rd_en, res_rd_addr, batch_done, (3 * b + k) % 42, (k == 2));
                else n_pass++;
                tick();
            end
            n_total++;
            if ({res_rd_en, batch_done} !== 2'b00)
                $display("FAIL burst%0d_end: got en=%b bd=%b want 0 0", b, res_rd_en, batch_done);
            else n_pass++;
            repeat (6) tick();
        end
    endtask

    task automatic test_rd_during_burst();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        tick();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_total++;
        if ({res_rd_en, res_rd_addr, batch_done} !== {1'b1, 6'd5, 1'b1})
            $display("FAIL midburst_last: got en=%b addr=%0d bd=%b want 1 5 1", res_rd_en, res_rd_addr, batch_done);
        else n_pass++;
        tick();
        n_total++;
        if (res_rd_en !== 1'b0) $display("FAIL midburst_len1: got en=%b want 0", res_rd_en);
        else n_pass++;
        tick();
        n_total++;
        if (res_rd_en !== 1'b0) $display("FAIL midburst_len2: got en=%b want 0", res_rd_en);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        tick(); tick();
        rd_en = 1'b1;
        tick();
        n_total++;
        if (res_rd_en !== 1'b0) $display("FAIL b2b_gap: got en=%b want 0", res_rd_en);
        else n_pass++;
        tick();
        rd_en = 1'b0;
        n_total++;
        if ({res_rd_en, res_rd_addr, batch_done} !== {1'b1, 6'd9, 1'b0})
            $display("FAIL b2b_second: got en=%b addr=%0d bd=%b want 1 9 0", res_rd_en, res_rd_addr, batch_done);
        else n_pass++;
        tick(); tick(); tick();
    endtask

    task automatic test_rd_with_cal_start();
        rd_en = 1'b1; cal_start = 1'b1; mode = 1'b1;
        tick();
        rd_en = 1'b0; cal_start = 1'b0; mode = 1'b0;
        n_total++;
        if ({res_rd_en, layer_start, busy, res_rd_addr, cal_done} !== {1'b0, 1'b1, 1'b1, 6'd0, 1'b0})
            $display("FAIL rd_vs_start: got en=%b ls=%b busy=%b addr=%0d done=%b want 0 1 1 0 0",
                     res_rd_en, layer_start, busy, res_rd_addr, cal_done);
        else n_pass++;
    endtask

    // Entered from the LAUNCH cycle left by test_rd_with_cal_start.
    task automatic test_timeout();
        repeat (20) tick();
        n_total++;
        if ({timeout_err, busy} !== 2'b01)
            $display("FAIL timeout_early: got err=%b busy=%b want 0 1", timeout_err, busy);
        else n_pass++;
        tick();
        n_total++;
        if ({timeout_err, busy, cal_done} !== 3'b100)
            $display("FAIL timeout_fire: got err=%b busy=%b done=%b want 1 0 0", timeout_err, busy, cal_done);
        else n_pass++;
        cal_start = 1'b1; mode = 1'b0;
        tick();
        cal_start = 1'b0;
        n_total++;
        if ({timeout_err, layer_start, layer_idx, ch_cfg} !== {1'b0, 1'b1, 2'd0, 6'd4})
            $display("FAIL timeout_restart: got err=%b ls=%b idx=%0d ch=%0d want 0 1 0 4",
                     timeout_err, layer_start, layer_idx, ch_cfg);
        else n_pass++;
        repeat (20) tick();
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        n_total++;
        if ({timeout_err, layer_start, layer_idx, ch_cfg} !== {1'b0, 1'b1, 2'd1, 6'd8})
            $display("FAIL done_beats_timeout: got err=%b ls=%b idx=%0d ch=%0d want 0 1 1 8",
                     timeout_err, layer_start, layer_idx, ch_cfg);
        else n_pass++;
    endtask

    // Entered from the LAUNCH cycle of layer 1.
    task automatic test_reset_mid();
        int bad;
        tick(); tick();
        layer_done = 1'b1; tick(); layer_done = 1'b0;
        n_total++;
        if ({layer_start, layer_idx} !== {1'b1, 2'd2})
            $display("FAIL pre_reset_l2: got ls=%b idx=%0d want 1 2", layer_start, layer_idx);
        else n_pass++;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (outs() !== RESET_VEC) $display("FAIL mid_reset: got %h want %h", outs(), RESET_VEC);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (outs() !== RESET_VEC) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL post_reset_idle: got %0d non-idle cycles want 0", bad);
        else n_pass++;
        cal_start = 1'b1; mode = 1'b1;
        tick();
        cal_start = 1'b0; mode = 1'b0;
        n_total++;
        if ({layer_start, busy, layer_idx, ch_cfg} !== {1'b1, 1'b1, 2'd0, 6'd8})
            $display("FAIL post_reset_start: got ls=%b busy=%b idx=%0d ch=%0d want 1 1 0 8",
                     layer_start, busy, layer_idx, ch_cfg);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_run(1'b1, {6'd10, 6'd32, 6'd16, 6'd8}, 1'b0);
        test_run(1'b0, {6'd10, 6'd16, 6'd8, 6'd4}, 1'b1);
        test_readout();
        test_rd_during_burst();
        test_back_to_back();
        test_rd_with_cal_start();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
